// File: rtl/tsu_queue_arb.sv
// Drains the RX and TX tsu timestamp queues of one port into a single host stream
// with source tag, round-robin or RX-priority arbitration, and per-source drain counters.
module tsu_queue_arb #(
   parameter bit RX_PRIORITY = 1'b0
) (
   input  logic         q_rd_clk,
   input  logic         q_rst,
   input  logic         arb_en,
   input  logic [7:0]   rx_q_rd_stat,
   input  logic [127:0] rx_q_rd_data,
   output logic         rx_q_rd_en,
   input  logic [7:0]   tx_q_rd_stat,
   input  logic [127:0] tx_q_rd_data,
   output logic         tx_q_rd_en,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_src,
   input  logic         cnt_clr,
   output logic [15:0]  rx_cnt,
   output logic [15:0]  tx_cnt,
   output logic [8:0]   pend_total
);

   localparam int unsigned DW = 128;
   localparam int unsigned SW = 8;
   localparam int unsigned PW = SW + 1;
   localparam int unsigned CW = 16;
   localparam logic SRC_RX = 1'b0;
   localparam logic SRC_TX = 1'b1;

   typedef enum logic [1:0] {IDLE, READ, CAPTURE, HOLD} state_e;

   state_e        state_q, state_d;
   logic          sel_q, sel_d;
   logic          last_q, last_d;
   logic          rx_en_q, rx_en_d;
   logic          tx_en_q, tx_en_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic          src_q, src_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic          rx_pend, tx_pend, grant_tx, start;

   // Grant TX only if RX is empty, or round-robin says RX went last.
   always_comb begin
      rx_pend  = (rx_q_rd_stat != '0);
      tx_pend  = (tx_q_rd_stat != '0);
      grant_tx = !rx_pend || (!RX_PRIORITY && tx_pend && (last_q == SRC_RX));
      start    = (state_q == IDLE) && arb_en && (rx_pend || tx_pend);
   end

   always_ff @(posedge q_rd_clk) begin
      if (q_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = READ;
         READ:    state_d = CAPTURE;
         CAPTURE: state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_d    = sel_q;
      last_d   = last_q;
      rx_en_d  = 1'b0;
      tx_en_d  = 1'b0;
      valid_d  = 1'b0;
      data_d   = data_q;
      src_d    = src_q;
      rx_cnt_d = rx_cnt_q;
      tx_cnt_d = tx_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d   = grant_tx;
               last_d  = grant_tx;
               rx_en_d = !grant_tx;
               tx_en_d = grant_tx;
            end
         end
         CAPTURE: begin
            data_d  = (sel_q == SRC_TX) ? tx_q_rd_data : rx_q_rd_data;
            src_d   = sel_q;
            valid_d = 1'b1;
         end
         HOLD: begin
            valid_d = !out_ready;
            if (out_ready) begin
               if (src_q == SRC_TX) tx_cnt_d = tx_cnt_q + CW'(1);
               else                 rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
      // Clear wins over a coincident increment.
      if (cnt_clr) begin
         rx_cnt_d = '0;
         tx_cnt_d = '0;
      end
   end

   always_ff @(posedge q_rd_clk) begin
      if (q_rst) begin
         sel_q    <= SRC_RX;
         last_q   <= SRC_TX;
         rx_en_q  <= 1'b0;
         tx_en_q  <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         src_q    <= SRC_RX;
         rx_cnt_q <= '0;
         tx_cnt_q <= '0;
      end else begin
         sel_q    <= sel_d;
         last_q   <= last_d;
         rx_en_q  <= rx_en_d;
         tx_en_q  <= tx_en_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         src_q    <= src_d;
         rx_cnt_q <= rx_cnt_d;
         tx_cnt_q <= tx_cnt_d;
      end
   end

   assign rx_q_rd_en = rx_en_q;
   assign tx_q_rd_en = tx_en_q;
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_src    = src_q;
   assign rx_cnt     = rx_cnt_q;
   assign tx_cnt     = tx_cnt_q;
   assign pend_total = PW'(rx_q_rd_stat) + PW'(tx_q_rd_stat);

endmodule
